// File: rtl/nav_pkg.sv
// Shared types and step constants for the navigation controller.
package nav_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdng  = 3'd1,
    StMove  = 3'd2,
    StDecel = 3'd3,
    StBrake = 3'd4
  } nav_state_t;

  localparam logic [10:0] INC_NORM  = 11'h018;
  localparam logic [10:0] INC_FAST  = 11'h060;
  localparam int unsigned BRK_SHIFT = 2;

  function automatic logic [10:0] ramp_step(input bit fast_sim);
    return fast_sim ? INC_FAST : INC_NORM;
  endfunction

endpackage

// File: rtl/nav_ctrl_if.sv
// Command, sensor and PID-facing signals of the navigation controller.
interface nav_ctrl_if;
  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic        hdng_vld;
  logic        at_hdng;
  logic        lft_opn;
  logic        rght_opn;
  logic        frwrd_opn;
  logic        moving;
  logic [10:0] frwrd_spd;
  logic        en_fusion;
  logic        mv_cmplt;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, hdng_vld, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    input  moving, frwrd_spd, en_fusion, mv_cmplt
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, hdng_vld, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    output moving, frwrd_spd, en_fusion, mv_cmplt
  );
endinterface

// File: rtl/opn_edge_det.sv
// Rising-edge detector for an IR opening flag; preload resyncs the history to the live flag.
module opn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic preload,
  input  logic din,
  output logic rise
);

  logic prev_q;

  // History resets high so a flag already set out of reset is never an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= din;
    end
  end

  assign rise = din & ~prev_q & ~preload;

endmodule

// File: rtl/nav_ctrl.sv
// Move-level navigation controller: heading/move sequencing and forward-speed ramp for the PID.
module nav_ctrl
  import nav_pkg::*;
#(
  parameter bit          FAST_SIM  = 1'b0,
  parameter logic [10:0] MIN_FRWRD = 11'h0D0,
  parameter logic [10:0] MAX_FRWRD = 11'h2A0
) (
  input logic       clk,
  input logic       rst_n,
  nav_ctrl_if.slave bus
);

  localparam logic [10:0] INC = ramp_step(FAST_SIM);
  localparam logic [10:0] DEC = INC;
  localparam logic [10:0] BRK = INC << BRK_SHIFT;

  nav_state_t  state_q, state_d;
  logic [10:0] spd_q, spd_d;
  logic        cmplt_q, cmplt_d;
  logic        stp_lft_q, stp_lft_d;
  logic        stp_rght_q, stp_rght_d;
  logic        mv_start;
  logic        lft_rise, rght_rise;
  logic [11:0] sum, diff;
  logic [10:0] inc_spd;
  logic        dec_done;

  opn_edge_det u_lft_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .preload (mv_start),
    .din     (bus.lft_opn),
    .rise    (lft_rise)
  );

  opn_edge_det u_rght_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .preload (mv_start),
    .din     (bus.rght_opn),
    .rise    (rght_rise)
  );

  // 12-bit arithmetic: bit 11 is carry on the ramp-up and borrow on the ramp-down.
  always_comb begin
    sum      = {1'b0, spd_q} + {1'b0, INC};
    inc_spd  = (sum[11] || (sum[10:0] > MAX_FRWRD)) ? MAX_FRWRD : sum[10:0];
    diff     = {1'b0, spd_q} - {1'b0, ((state_q == StBrake) ? BRK : DEC)};
    dec_done = diff[11] || (diff[10:0] < MIN_FRWRD);
  end

  always_comb begin
    state_d    = state_q;
    spd_d      = spd_q;
    cmplt_d    = 1'b0;
    stp_lft_d  = stp_lft_q;
    stp_rght_d = stp_rght_q;
    mv_start   = 1'b0;

    case (state_q)
      StIdle: begin
        spd_d = '0;
        if (bus.strt_hdng) begin
          state_d = StHdng;
        end else if (bus.strt_mv) begin
          state_d    = StMove;
          spd_d      = MIN_FRWRD;
          stp_lft_d  = bus.stp_lft;
          stp_rght_d = bus.stp_rght;
          mv_start   = 1'b1;
        end
      end
      StHdng: begin
        spd_d = '0;
        if (bus.at_hdng && bus.hdng_vld) begin
          state_d = StIdle;
          cmplt_d = 1'b1;
        end
      end
      StMove: begin
        if (!bus.frwrd_opn) begin
          state_d = StBrake;
        end else if ((lft_rise && stp_lft_q) || (rght_rise && stp_rght_q)) begin
          state_d = StDecel;
        end else if (bus.hdng_vld) begin
          spd_d = inc_spd;
        end
      end
      StDecel, StBrake: begin
        if ((state_q == StDecel) && !bus.frwrd_opn) begin
          state_d = StBrake;
        end else if (bus.hdng_vld) begin
          if (dec_done) begin
            state_d = StIdle;
            spd_d   = '0;
            cmplt_d = 1'b1;
          end else begin
            spd_d = diff[10:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        spd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      spd_q      <= '0;
      cmplt_q    <= 1'b0;
      stp_lft_q  <= 1'b0;
      stp_rght_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      spd_q      <= spd_d;
      cmplt_q    <= cmplt_d;
      stp_lft_q  <= stp_lft_d;
      stp_rght_q <= stp_rght_d;
    end
  end

  assign bus.moving    = (state_q != StIdle);
  assign bus.frwrd_spd = spd_q;
  assign bus.en_fusion = (spd_q > (MAX_FRWRD >> 1));
  assign bus.mv_cmplt  = cmplt_q;

endmodule

// File: tb/tb_nav_ctrl.sv
// Vector-table bench for nav_ctrl with a scoreboard of expected post-edge outputs.
module tb_nav_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nav_ctrl_if bus ();

  nav_ctrl #(
    .FAST_SIM  (1'b1),
    .MIN_FRWRD (11'h0D0),
    .MAX_FRWRD (11'h2A0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [8:0] NO = 9'h000;
  localparam logic [8:0] SH = 9'h100;
  localparam logic [8:0] SM = 9'h080;
  localparam logic [8:0] SL = 9'h040;
  localparam logic [8:0] SR = 9'h020;
  localparam logic [8:0] HV = 9'h010;
  localparam logic [8:0] AH = 9'h008;
  localparam logic [8:0] LO = 9'h004;
  localparam logic [8:0] RO = 9'h002;
  localparam logic [8:0] FO = 9'h001;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic [8:0]  in;
    logic        em;
    logic [10:0] es;
    logic        ef;
    logic        ec;
    string       nm;
  } vec_t;

  typedef struct {
    logic        em;
    logic [10:0] es;
    logic        ef;
    logic        ec;
    string       nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic [8:0] in, input logic em, input logic [10:0] es,
                              input logic ef, input logic ec, input string nm);
    vec_t v;
    v.in = in; v.em = em; v.es = es; v.ef = ef; v.ec = ec; v.nm = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] in);
    bus.strt_hdng = in[8];
    bus.strt_mv   = in[7];
    bus.stp_lft   = in[6];
    bus.stp_rght  = in[5];
    bus.hdng_vld  = in[4];
    bus.at_hdng   = in[3];
    bus.lft_opn   = in[2];
    bus.rght_opn  = in[1];
    bus.frwrd_opn = in[0];
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v.in);
    e.em = v.em; e.es = v.es; e.ef = v.ef; e.ec = v.ec; e.nm = v.nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.nm, ".moving"},    11'(bus.moving),    11'(e.em));
    check({e.nm, ".frwrd_spd"}, bus.frwrd_spd,      e.es);
    check({e.nm, ".en_fusion"}, 11'(bus.en_fusion), 11'(e.ef));
    check({e.nm, ".mv_cmplt"},  11'(bus.mv_cmplt),  11'(e.ec));
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".moving"},    11'(bus.moving),    11'd0);
    check({nm, ".frwrd_spd"}, bus.frwrd_spd,      11'd0);
    check({nm, ".en_fusion"}, 11'(bus.en_fusion), 11'd0);
    check({nm, ".mv_cmplt"},  11'(bus.mv_cmplt),  11'd0);
  endtask

  initial begin
    drive(FO);
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp to saturation, then brake on a blocked front
    add(FO, N, 11'h000, N, N, "idle");
    add(SM | FO, Y, 11'h0D0, N, N, "mv_start");
    add(HV | FO, Y, 11'h130, N, N, "ramp1");
    add(HV | FO, Y, 11'h190, Y, N, "ramp2");
    add(HV | FO, Y, 11'h1F0, Y, N, "ramp3");
    add(HV | FO, Y, 11'h250, Y, N, "ramp4");
    add(HV | FO, Y, 11'h2A0, Y, N, "ramp5");
    for (int i = 0; i < 5; i++) add(HV | FO, Y, 11'h2A0, Y, N, "ramp_sat");
    add(NO, Y, 11'h2A0, Y, N, "brk_enter");
    add(HV, Y, 11'h120, N, N, "brk1");
    add(HV, N, 11'h000, N, Y, "brk_done");
    add(FO, N, 11'h000, N, N, "cmplt_one_cycle");

    // Heading: at_hdng alone never completes, hdng_vld qualifies it
    add(SH | FO, Y, 11'h000, N, N, "hdng_start");
    for (int i = 0; i < 5; i++) add(AH | FO, Y, 11'h000, N, N, "hdng_wait");
    add(HV | FO, Y, 11'h000, N, N, "hdng_vld_only");
    add(AH | HV | FO, N, 11'h000, N, Y, "hdng_done");
    add(FO, N, 11'h000, N, N, "hdng_cmplt_one");

    // Left opening present at start must not stop; a fresh edge does
    add(SM | SL | LO | FO, Y, 11'h0D0, N, N, "mvl_start");
    add(HV | LO | FO, Y, 11'h130, N, N, "mvl1");
    add(HV | LO | FO, Y, 11'h190, Y, N, "mvl2");
    add(HV | LO | FO, Y, 11'h1F0, Y, N, "mvl3");
    add(HV | LO | FO, Y, 11'h250, Y, N, "mvl4");
    add(HV | LO | FO, Y, 11'h2A0, Y, N, "mvl5");
    add(LO | FO, Y, 11'h2A0, Y, N, "lft_held");
    add(FO, Y, 11'h2A0, Y, N, "lft_close");
    add(LO | FO, Y, 11'h2A0, Y, N, "lft_rise");
    add(HV | LO | FO, Y, 11'h240, Y, N, "dec1");
    add(HV | LO | FO, Y, 11'h1E0, Y, N, "dec2");
    add(HV | LO | FO, Y, 11'h180, Y, N, "dec3");
    add(HV | LO | FO, Y, 11'h120, N, N, "dec4");
    add(HV | LO | FO, N, 11'h000, N, Y, "dec_done");

    // Right stop only; left edge ignored; blocked front during DECEL goes to BRAKE
    add(SM | SR | FO, Y, 11'h0D0, N, N, "mvr_start");
    add(HV | FO, Y, 11'h130, N, N, "mvr1");
    add(HV | FO, Y, 11'h190, Y, N, "mvr2");
    add(HV | FO, Y, 11'h1F0, Y, N, "mvr3");
    add(HV | FO, Y, 11'h250, Y, N, "mvr4");
    add(HV | FO, Y, 11'h2A0, Y, N, "mvr5");
    add(LO | FO, Y, 11'h2A0, Y, N, "lft_nostop");
    add(HV | LO | FO, Y, 11'h2A0, Y, N, "still_move");
    add(RO | LO | FO, Y, 11'h2A0, Y, N, "rght_rise");
    add(RO | LO, Y, 11'h2A0, Y, N, "dec_to_brk");
    add(HV | RO | LO, Y, 11'h120, N, N, "brkr1");
    add(HV | RO | LO, N, 11'h000, N, Y, "brkr_done");

    // Simultaneous starts, ignored start, restart on the completion cycle
    add(SH | SM | FO, Y, 11'h000, N, N, "both_strt");
    add(SM | FO, Y, 11'h000, N, N, "mv_in_hdng");
    add(HV | FO, Y, 11'h000, N, N, "hv_in_hdng");
    add(AH | HV | FO, N, 11'h000, N, Y, "hdng_done2");
    add(SM | FO, Y, 11'h0D0, N, N, "strt_on_cmplt");
    add(NO, Y, 11'h0D0, N, N, "brk_from_min");
    add(HV, N, 11'h000, N, Y, "brk_min_done");
    add(FO, N, 11'h000, N, N, "idle2");
    run_vecs();

    // Asynchronous reset in the middle of a move
    add(SM | FO, Y, 11'h0D0, N, N, "pre_rst_start");
    add(HV | FO, Y, 11'h130, N, N, "pre_rst1");
    add(HV | FO, Y, 11'h190, Y, N, "pre_rst2");
    add(HV | FO, Y, 11'h1F0, Y, N, "pre_rst3");
    run_vecs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    add(FO, N, 11'h000, N, N, "post_rst_idle");
    add(SM | FO, Y, 11'h0D0, N, N, "restart");
    add(HV | FO, Y, 11'h130, N, N, "restart_ramp");
    run_vecs();

    check("sb_empty", 11'(sb.size()), 11'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
